// File: rtl/tmds_pkg.sv
// Shared constants, pixel bundle type and popcount helper for the
// three-channel TMDS encoder.
package tmds_pkg;

    localparam int DISP_W = 5;

    localparam logic [9:0] CTL_00 = 10'h354;
    localparam logic [9:0] CTL_01 = 10'h0AB;
    localparam logic [9:0] CTL_10 = 10'h154;
    localparam logic [9:0] CTL_11 = 10'h2AB;

    // HDMI video guard-band symbols, indexed by channel
    localparam logic [9:0] GB_VID_0 = 10'h2CC;
    localparam logic [9:0] GB_VID_1 = 10'h133;
    localparam logic [9:0] GB_VID_2 = 10'h2CC;

    typedef struct packed {
        logic       de;
        logic       hsync;
        logic       vsync;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 builds the transition-minimised q_m word,
// stage 2 applies running-disparity balancing or emits a control symbol.
module tmds_channel_enc
    import tmds_pkg::*;
#(
    parameter logic [9:0] C_ctl_reset = CTL_00
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_de,
    input  logic       i_c0,
    input  logic       i_c1,
    output logic [9:0] o_symbol
);

    logic [3:0]              n1_in;
    logic                    use_xnor;
    logic [8:0]              qm_d, qm_q;
    logic                    de_q, c0_q, c1_q;
    logic [3:0]              n1_qm, n0_qm;
    logic signed [5:0]       cnt_ext, diff, cnt_sum;
    logic signed [DISP_W-1:0] cnt_d, cnt_q;
    logic [9:0]              sym_d, sym_q;

    always_comb begin
        n1_in    = popcount8(i_data);
        use_xnor = (n1_in > 4'd4) || (n1_in == 4'd4 && !i_data[0]);
        qm_d[0]  = i_data[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ i_data[i]) : (qm_d[i-1] ^ i_data[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            qm_q <= '0;
            de_q <= 1'b0;
            c0_q <= 1'b0;
            c1_q <= 1'b0;
        end else begin
            qm_q <= qm_d;
            de_q <= i_de;
            c0_q <= i_c0;
            c1_q <= i_c1;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        n1_qm   = popcount8(qm_q[7:0]);
        n0_qm   = 4'd8 - n1_qm;
        cnt_ext = {cnt_q[DISP_W-1], cnt_q};
        diff    = $signed({2'b00, n1_qm}) - $signed({2'b00, n0_qm});
        cnt_sum = cnt_ext;
        sym_d   = sym_q;
        if (!de_q) begin
            cnt_sum = '0;
            case ({c1_q, c0_q})
                2'b00:   sym_d = CTL_00;
                2'b01:   sym_d = CTL_01;
                2'b10:   sym_d = CTL_10;
                default: sym_d = CTL_11;
            endcase
        end else if (cnt_q == '0 || n1_qm == n0_qm) begin
            sym_d   = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_sum = qm_q[8] ? cnt_ext + diff : cnt_ext - diff;
        end else if ((!cnt_q[DISP_W-1] && n1_qm > n0_qm) ||
                     ( cnt_q[DISP_W-1] && n0_qm > n1_qm)) begin
            sym_d   = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_sum = cnt_ext + (qm_q[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            sym_d   = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_sum = cnt_ext - (qm_q[8] ? 6'sd0 : 6'sd2) + diff;
        end
        // disparity stays within -8..+8, so dropping the sixth bit is lossless
        cnt_d = cnt_sum[DISP_W-1:0];
    end

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            sym_q <= C_ctl_reset;
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_symbol = sym_q;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// Three-channel DVI/HDMI TMDS encoder. Defining TMDS_HDMI_GUARD_EN adds a
// 10-pixel look-ahead delay line that inserts HDMI preamble and guard bands.
module tmds_encoder_3ch
    import tmds_pkg::*;
#(
    parameter bit         C_invert_sync = 1'b0,
    parameter logic [9:0] C_ctl_reset   = 10'b1101010100
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_blank,
    output logic [9:0] o_tmds_r,
    output logic [9:0] o_tmds_g,
    output logic [9:0] o_tmds_b
);

    pix_t       pix_in, enc_pix;
    logic       ch1_c0;
    logic [9:0] sym_r, sym_g, sym_b;

    always_comb begin
        pix_in.de    = ~i_blank;
        pix_in.hsync = i_hsync ^ C_invert_sync;
        pix_in.vsync = i_vsync ^ C_invert_sync;
        pix_in.r     = i_r;
        pix_in.g     = i_g;
        pix_in.b     = i_b;
    end

`ifdef TMDS_HDMI_GUARD_EN
    localparam int DL_DEPTH = 10;

    pix_t                dl_d [DL_DEPTH];
    pix_t                dl_q [DL_DEPTH];
    logic [DL_DEPTH-1:0] la_de;
    logic                guard_now, pre_now;
    logic [1:0]          gb_d, gb_q;

    always_comb begin
        dl_d[0] = pix_in;
        for (int i = 1; i < DL_DEPTH; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        enc_pix = dl_q[DL_DEPTH-1];
        // la_de[k-1] is the de of the pixel k positions after the one being encoded
        for (int k = 1; k < DL_DEPTH; k++) begin
            la_de[k-1] = dl_q[DL_DEPTH-1-k].de;
        end
        la_de[DL_DEPTH-1] = pix_in.de;
        guard_now = ~enc_pix.de & (la_de[0] | la_de[1]);
        pre_now   = ~enc_pix.de & ~guard_now & (|la_de[DL_DEPTH-1:2]);
        ch1_c0    = pre_now;
        gb_d      = {gb_q[0], guard_now};
    end

    // NOTE: the delay line is reset so the pipeline drains as clean blanking after rst.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DL_DEPTH; i++) begin
                dl_q[i] <= '0;
            end
            gb_q <= '0;
        end else begin
            for (int i = 0; i < DL_DEPTH; i++) begin
                dl_q[i] <= dl_d[i];
            end
            gb_q <= gb_d;
        end
    end

    assign o_tmds_b = gb_q[1] ? GB_VID_0 : sym_b;
    assign o_tmds_g = gb_q[1] ? GB_VID_1 : sym_g;
    assign o_tmds_r = gb_q[1] ? GB_VID_2 : sym_r;
`else
    always_comb begin
        enc_pix = pix_in;
        ch1_c0  = 1'b0;
    end

    assign o_tmds_b = sym_b;
    assign o_tmds_g = sym_g;
    assign o_tmds_r = sym_r;
`endif

    tmds_channel_enc #(.C_ctl_reset(C_ctl_reset)) u_ch0 (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .i_data    (enc_pix.b),
        .i_de      (enc_pix.de),
        .i_c0      (enc_pix.hsync),
        .i_c1      (enc_pix.vsync),
        .o_symbol  (sym_b)
    );

    tmds_channel_enc #(.C_ctl_reset(C_ctl_reset)) u_ch1 (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .i_data    (enc_pix.g),
        .i_de      (enc_pix.de),
        .i_c0      (ch1_c0),
        .i_c1      (1'b0),
        .o_symbol  (sym_g)
    );

    tmds_channel_enc #(.C_ctl_reset(C_ctl_reset)) u_ch2 (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .i_data    (enc_pix.r),
        .i_de      (enc_pix.de),
        .i_c0      (1'b0),
        .i_c1      (1'b0),
        .o_symbol  (sym_r)
    );

endmodule
